// File: rtl/step_seq_ctrl_pkg.sv
// rtl/step_seq_ctrl_pkg.sv - shared FSM state encoding and error codes for step_seq_ctrl
package step_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK0 = 3'd1,
        S_STEP   = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ABORT   = 2'd2;
    localparam logic [1:0] ERR_STALL   = 2'd3;

    // settle countdown only needs to cover 1..3 cycles
    localparam int SETTLE_W = 2;

endpackage

// File: rtl/step_seq_ctrl_if.sv
// rtl/step_seq_ctrl_if.sv - command handshake channel into step_seq_ctrl
interface step_seq_ctrl_if #(
    parameter int STATE_W = 2
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [STATE_W-1:0] cmd_target;
    logic               cmd_dir;

    modport master (output cmd_valid, output cmd_target, output cmd_dir, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_target, input cmd_dir, output cmd_ready);
endinterface

// File: rtl/step_pulse_timer.sv
// rtl/step_pulse_timer.sv - one-cycle step_en pulse followed by a SETTLE_CYC countdown
module step_pulse_timer
    import step_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic fire_i,
    input  logic clear_i,
    output logic step_en_o,
    output logic settle_done_o
);

    logic                step_en_q;
    logic [SETTLE_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_en_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            step_en_q <= fire_i && !clear_i;
            if (clear_i) begin
                cnt_q <= '0;
            end else if (step_en_q) begin
                cnt_q <= SETTLE_W'(SETTLE_CYC);
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - SETTLE_W'(1);
            end
        end
    end

    assign step_en_o     = step_en_q;
    assign settle_done_o = (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/step_seq_ctrl.sv
// rtl/step_seq_ctrl.sv - command-driven step sequencer for the 2-bit JK stepper datapath
// Optional STEP_SEQ_CTRL_REVERSE_ON_STALL_EN: reverse on first stall, stall error on second.
module step_seq_ctrl
    import step_seq_pkg::*;
#(
    parameter int STATE_W    = 2,
    parameter int MAX_STEPS  = 8,
    parameter int CNT_W      = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    step_seq_ctrl_if.slave     cmd,
    input  logic               abort,
    input  logic [STATE_W-1:0] state_in,
    output logic               step_en,
    output logic               step_dir,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [CNT_W-1:0]   step_count
);

    state_t             state_q;
    logic [STATE_W-1:0] target_q;
    logic               dir_q;
    logic               cmd_ready_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               step_dir_q;
    logic [1:0]         err_code_q;
    logic [CNT_W-1:0]   step_count_q;

    logic in_flight;
    logic hit;
    logic timeout;
    logic stall_err;
    logic reverse;
    logic launch;
    logic next_dir;
    logic settle_done;

    assign in_flight = (state_q == S_CHECK0) || (state_q == S_STEP) ||
                       (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign hit       = (state_in == target_q);
    assign timeout   = (step_count_q == CNT_W'(MAX_STEPS));

`ifdef STEP_SEQ_CTRL_REVERSE_ON_STALL_EN
    logic [STATE_W-1:0] prev_q;
    logic               stalled_q;
    logic               stall;

    assign stall     = (state_in == prev_q);
    assign stall_err = stall && stalled_q;
    assign reverse   = stall && !stalled_q;
`else
    assign stall_err = 1'b0;
    assign reverse   = 1'b0;
`endif

    // launch is the single point that decides a new pulse; abort vetoes it on the same edge
    assign launch   = !abort && !hit &&
                      ((state_q == S_CHECK0) ||
                       ((state_q == S_CHECK) && !timeout && !stall_err));
    assign next_dir = ((state_q == S_CHECK) && reverse) ? !dir_q : dir_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            target_q     <= '0;
            dir_q        <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            step_dir_q   <= 1'b0;
            err_code_q   <= ERR_NONE;
            step_count_q <= '0;
`ifdef STEP_SEQ_CTRL_REVERSE_ON_STALL_EN
            prev_q       <= '0;
            stalled_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (launch) begin
                step_dir_q <= next_dir;
            end
            // the pulse is already out during STEP, so it is counted even if abort wins
            if (state_q == S_STEP) begin
                if (step_count_q != CNT_W'(MAX_STEPS)) begin
                    step_count_q <= step_count_q + CNT_W'(1);
                end
`ifdef STEP_SEQ_CTRL_REVERSE_ON_STALL_EN
                prev_q <= state_in;
`endif
            end

            // DONE/ERR already resolved the command, so abort only matters while in flight
            if (in_flight && abort) begin
                state_q    <= S_ERR;
                err_q      <= 1'b1;
                err_code_q <= ERR_ABORT;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cmd.cmd_valid && cmd_ready_q) begin
                            target_q     <= cmd.cmd_target;
                            dir_q        <= cmd.cmd_dir;
                            step_count_q <= '0;
                            err_code_q   <= ERR_NONE;
                            busy_q       <= 1'b1;
                            cmd_ready_q  <= 1'b0;
                            state_q      <= S_CHECK0;
`ifdef STEP_SEQ_CTRL_REVERSE_ON_STALL_EN
                            stalled_q    <= 1'b0;
`endif
                        end
                    end
                    S_CHECK0: begin
                        if (hit) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_STEP;
                        end
                    end
                    S_STEP: state_q <= S_SETTLE;
                    S_SETTLE: begin
                        if (settle_done) begin
                            state_q <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (hit) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (timeout) begin
                            state_q    <= S_ERR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_TIMEOUT;
                        end else if (stall_err) begin
                            state_q    <= S_ERR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_STALL;
                        end else begin
                            state_q <= S_STEP;
                            dir_q   <= next_dir;
`ifdef STEP_SEQ_CTRL_REVERSE_ON_STALL_EN
                            stalled_q <= stalled_q | reverse;
`endif
                        end
                    end
                    S_DONE, S_ERR: begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    step_pulse_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .fire_i       (launch),
        .clear_i      (in_flight && abort),
        .step_en_o    (step_en),
        .settle_done_o(settle_done)
    );

    assign cmd.cmd_ready = cmd_ready_q;
    assign step_dir      = step_dir_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign step_count    = step_count_q;

endmodule

// File: tb/tb_step_seq_ctrl.sv
// tb/tb_step_seq_ctrl.sv - directed bench with a per-command timeline model for step_seq_ctrl
module tb_step_seq_ctrl;

    localparam int MAX_STEPS = 8;
    localparam int SETTLE    = 2;
    localparam int P         = SETTLE + 2;
`ifdef STEP_SEQ_CTRL_REVERSE_ON_STALL_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       abort;
    logic [1:0] state_in;
    logic       step_en, step_dir, busy, done, err;
    logic [1:0] err_code;
    logic [3:0] step_count;

    step_seq_ctrl_if #(.STATE_W(2)) cmd_if ();

    step_seq_ctrl #(
        .STATE_W   (2),
        .MAX_STEPS (MAX_STEPS),
        .CNT_W     (4),
        .SETTLE_CYC(SETTLE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd       (cmd_if),
        .abort     (abort),
        .state_in  (state_in),
        .step_en   (step_en),
        .step_dir  (step_dir),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .step_count(step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;
    int cyc;
    int t_acc;
    int ct;
    bit win_on;
    int win_len;

    // datapath stand-in: mode 0 normal (dir1 counts down), 1 stuck, 2 stalls only when dir=1
    int mode;
    int dp_state;
    int dp_seed;
    bit seed_req;
    int pulses;

    bit x_en   [0:63];
    bit x_dir  [0:63];
    bit x_busy [0:63];
    bit x_done [0:63];
    bit x_err  [0:63];
    int x_code [0:63];
    int x_cnt  [0:63];
    bit pulse_dir [0:15];
    bit last_dir;
    int m_n;
    int m_code;
    bit m_ok;

    function automatic int dp_next(input int s, input bit d, input int md);
        if (md == 1) return s;
        if (md == 2 && d) return s;
        return d ? (s + 3) % 4 : (s + 1) % 4;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (seed_req) begin
            dp_state <= dp_seed;
            pulses   <= 0;
        end else if (step_en) begin
            dp_state <= dp_next(dp_state, step_dir, mode);
            pulses   <= pulses + 1;
        end
    end
    assign state_in = 2'(dp_state);

    // Whole-command outcome first, then a cycle timeline: pulse k lands on cycle 2+(k-1)*P
    task automatic build_model(input int s0, input int tgt, input bit d0, input int md, input int ta);
        int  s, ns, n, stalls, fin, code, last_k;
        bit  d, ok, stall;
        s = s0; d = d0; n = 0; stalls = 0; ok = (s0 == tgt); code = 0;
        while (!ok && code == 0) begin
            pulse_dir[n] = d;
            n++;
            ns = dp_next(s, d, md);
            stall = (ns == s);
            s = ns;
            if (s == tgt) ok = 1'b1;
            else if (n == MAX_STEPS) code = 1;
            else if (REV && stall) begin
                if (stalls > 0) code = 3;
                else begin stalls = 1; d = !d; end
            end
        end
        fin = 2 + n * P;
        if (ta > 0 && ta < fin) begin
            ok = 1'b0; code = 2; fin = ta + 1;
            n = 0;
            while (2 + n * P <= ta) n++;
        end
        for (int t = 1; t <= fin + 1; t++) begin
            x_en[t] = 1'b0; x_cnt[t] = 0; last_k = 0;
            for (int k = 1; k <= n; k++) begin
                if (2 + (k - 1) * P == t) x_en[t] = 1'b1;
                if (2 + (k - 1) * P < t) x_cnt[t]++;
                if (2 + (k - 1) * P <= t) last_k = k;
            end
            x_dir[t]  = (last_k > 0) ? pulse_dir[last_k - 1] : last_dir;
            x_busy[t] = (t <= fin);
            x_done[t] = (t == fin) && ok;
            x_err[t]  = (t == fin) && !ok;
            x_code[t] = (t >= fin) ? code : 0;
        end
        win_len = fin + 1;
        m_n = n; m_ok = ok; m_code = code;
    endtask

    always @(negedge clk) begin
        if (win_on) begin
            ct = cyc - t_acc + 1;
            if (ct >= 1 && ct <= win_len) begin
                chk("step_en",    int'(step_en),          int'(x_en[ct]));
                chk("step_dir",   int'(step_dir),         int'(x_dir[ct]));
                chk("busy",       int'(busy),             int'(x_busy[ct]));
                chk("cmd_ready",  int'(cmd_if.cmd_ready), int'(!x_busy[ct]));
                chk("done",       int'(done),             int'(x_done[ct]));
                chk("err",        int'(err),              int'(x_err[ct]));
                chk("err_code",   int'(err_code),         x_code[ct]);
                chk("step_count", int'(step_count),       x_cnt[ct]);
            end
        end
    end

    task automatic seed(input int s0, input int md);
        mode = md; dp_seed = s0; seed_req = 1'b1;
        @(posedge clk); #1;
        seed_req = 1'b0;
    endtask

    task automatic run_cmd(input int s0, input int tgt, input bit d0, input int md,
                           input int ta, input bit hold, input bit ab_idle);
        int guard;
        seed(s0, md);
        guard = 0;
        while (!cmd_if.cmd_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        chk("ready_before_cmd", int'(cmd_if.cmd_ready), 1);
        build_model(s0, tgt, d0, md, ta);
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_target = 2'(tgt); cmd_if.cmd_dir = d0; abort = ab_idle;
        @(posedge clk); #1;
        t_acc = cyc; win_on = 1'b1;
        cmd_if.cmd_target = 2'(~tgt); cmd_if.cmd_dir = !d0;
        for (int t = 1; t <= win_len; t++) begin
            abort = (t == ta);
            cmd_if.cmd_valid = hold && (t < win_len);
            @(posedge clk); #1;
        end
        win_on = 1'b0; abort = 1'b0; cmd_if.cmd_valid = 1'b0;
        last_dir = x_dir[win_len];
    endtask

    initial begin
        int guard;
        n_pass = 0; n_total = 0; win_on = 1'b0; seed_req = 1'b0; last_dir = 1'b0;
        mode = 0; dp_seed = 0;
        reset_n = 1'b0; abort = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_target = 2'b00; cmd_if.cmd_dir = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_cmd_ready",  int'(cmd_if.cmd_ready), 1);
        chk("rst_step_en",    int'(step_en), 0);
        chk("rst_step_dir",   int'(step_dir), 0);
        chk("rst_busy",       int'(busy), 0);
        chk("rst_done",       int'(done), 0);
        chk("rst_err",        int'(err), 0);
        chk("rst_err_code",   int'(err_code), 0);
        chk("rst_step_count", int'(step_count), 0);

        // zero-step: done two cycles after accept
        run_cmd(1, 1, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("zero_model_fin", win_len - 1, 2);
        chk("zero_pulses", pulses, 0);
        chk("zero_count", int'(step_count), 0);

        // 00 -> 11 -> 10 with dir=1
        run_cmd(0, 2, 1'b1, 0, 0, 1'b0, 1'b0);
        chk("normal_model_n", m_n, 2);
        chk("normal_pulses", pulses, 2);
        chk("normal_count", int'(step_count), 2);
        chk("normal_dir", int'(step_dir), 1);

        // abort with the accept cycle, valid held while busy, target scrambled after accept
        run_cmd(3, 1, 1'b0, 0, 0, 1'b1, 1'b1);
        chk("hold_pulses", pulses, 2);
        chk("hold_count", int'(step_count), 2);
        chk("hold_code", int'(err_code), 0);

`ifndef STEP_SEQ_CTRL_REVERSE_ON_STALL_EN
        run_cmd(0, 3, 1'b0, 1, 0, 1'b0, 1'b0);
        chk("timeout_model_code", m_code, 1);
        chk("timeout_pulses", pulses, 8);
        chk("timeout_count", int'(step_count), 8);
        chk("timeout_code", int'(err_code), 1);
`else
        run_cmd(0, 3, 1'b0, 1, 0, 1'b0, 1'b0);
        chk("stall2_model_code", m_code, 3);
        chk("stall2_pulses", pulses, 2);
        chk("stall2_code", int'(err_code), 3);

        run_cmd(0, 1, 1'b1, 2, 0, 1'b0, 1'b0);
        chk("reverse_model_ok", int'(m_ok), 1);
        chk("reverse_pulses", pulses, 2);
        chk("reverse_dir", int'(step_dir), 0);
        chk("reverse_count", int'(step_count), 2);
`endif

        // abort during the 2nd SETTLE: 2nd pulse at cycle 2+P, its first settle cycle next
        run_cmd(0, 3, 1'b0, 0, 2 + P + 1, 1'b0, 1'b0);
        chk("abort_model_code", m_code, 2);
        chk("abort_pulses", pulses, 2);
        chk("abort_code", int'(err_code), 2);
        chk("abort_ready", int'(cmd_if.cmd_ready), 1);

        // reset while step_en is high drops it immediately
        seed(0, 0);
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_target = 2'b10; cmd_if.cmd_dir = 1'b0;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        guard = 0;
        while (!step_en && guard < 20) begin @(posedge clk); #1; guard++; end
        chk("midrst_pulse_seen", int'(step_en), 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_step_en", int'(step_en), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(cmd_if.cmd_ready), 1);
        chk("midrst_count", int'(step_count), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
